// File: rtl/fpu_move_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fpu_move_pipe
// Brief    : FMV.X.F / FMV.F.X move unit with illegal-opcode flag and a
//            DEPTH-entry result FIFO behind valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_move_pipe #(
    parameter int XLEN  = 32,
    parameter int FLEN  = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               opcode,
    input  logic [XLEN-1:0]          move_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          move_out,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW           = $clog2(DEPTH);
    localparam int            CW           = AW + 1;
    localparam logic [CW-1:0] C_DEPTH      = CW'(DEPTH);
    localparam logic [1:0]    C_OP_FMV_X_F = 2'b01;
    localparam logic [1:0]    C_OP_FMV_F_X = 2'b10;

    logic [XLEN-1:0] r_data [DEPTH];
    logic            r_ill  [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_count;

    logic [XLEN-1:0] w_sext;
    logic [XLEN-1:0] w_box;
    logic [XLEN-1:0] w_result;
    logic            w_illegal;
    logic            w_push;
    logic            w_pop;

    generate
        if (XLEN > FLEN) begin : g_widen
            logic w_unused_hi;
            assign w_sext      = {{(XLEN-FLEN){move_in[FLEN-1]}}, move_in[FLEN-1:0]};
            assign w_box       = {{(XLEN-FLEN){1'b1}}, move_in[FLEN-1:0]};
            assign w_unused_hi = ^move_in[XLEN-1:FLEN];
        end else begin : g_same
            assign w_sext = move_in;
            assign w_box  = move_in;
        end
    endgenerate

    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (opcode)
            C_OP_FMV_X_F: w_result  = w_sext;
            C_OP_FMV_F_X: w_result  = w_box;
            default:      w_illegal = 1'b1;
        endcase
    end

    // in_ready depends only on registered occupancy and rst, never on out_ready.
    assign in_ready    = !rst && (r_count < C_DEPTH);
    assign out_valid   = (r_count != '0);
    assign w_push      = in_valid && in_ready;
    assign w_pop       = out_valid && out_ready;
    assign move_out    = out_valid ? r_data[r_rd] : '0;
    assign out_illegal = out_valid ? r_ill[r_rd]  : 1'b0;
    assign count       = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_ill[i]  <= 1'b0;
            end
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wr] <= w_result;
                r_ill[r_wr]  <= w_illegal;
                r_wr         <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_move_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_move_pipe
// Brief    : Scoreboard bench for fpu_move_pipe (32/16 and 16/16 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_move_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [1:0]  opcode;
    logic [31:0] move_in, move_out;
    logic [1:0]  count;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
    logic [1:0]  b_opcode;
    logic [15:0] b_move_in, b_move_out;
    logic [1:0]  b_count;
    logic        b_flush;

    typedef struct packed { logic [31:0] d; logic ill; } exp_t;
    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;
    int max_cnt = 0;

    always #5 clk = ~clk;

    fpu_move_pipe #(.XLEN(32), .FLEN(16), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .move_in(move_in), .out_valid(out_valid), .out_ready(out_ready),
        .move_out(move_out), .out_illegal(out_illegal), .count(count)
    );

    fpu_move_pipe #(.XLEN(16), .FLEN(16), .DEPTH(2)) u_dut16 (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .opcode(b_opcode), .move_in(b_move_in), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .move_out(b_move_out), .out_illegal(b_out_illegal), .count(b_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every delivered head against the oldest expectation.
    always @(negedge clk) begin
        if (int'(count) > max_cnt) max_cnt = int'(count);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got 0x%08h expected no output at %0t", move_out, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_move_out", move_out, e.d);
                chk("sb_illegal", {31'b0, out_illegal}, {31'b0, e.ill});
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [31:0] ed,
                        input logic eill, input int ecnt);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        opcode   = op;
        move_in  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else @(posedge clk);
        end
        if (!ok) begin
            chk("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (ecnt >= 0) chk("count_at_accept", {30'b0, count}, ecnt);
        @(posedge clk);
        q.push_back('{d: ed, ill: eill});
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; opcode = 2'b00; move_in = '0; out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_opcode = 2'b00; b_move_in = '0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_move_out", move_out, 32'd0);
        chk("rst_illegal", {31'b0, out_illegal}, 32'd0);
        chk("rst_count", {30'b0, count}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Back-to-back stream with consumer always ready.
        out_ready = 1'b1;
        send(2'b01, 32'h1234_C0A0, 32'hFFFF_C0A0, 1'b0, 0);
        send(2'b01, 32'h0000_3F80, 32'h0000_3F80, 1'b0, 1);
        send(2'b10, 32'hABCD_3F80, 32'hFFFF_3F80, 1'b0, 1);
        send(2'b00, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1);
        send(2'b11, 32'h1234_5678, 32'h0000_0000, 1'b1, 1);
        send(2'b10, 32'h0000_1111, 32'hFFFF_1111, 1'b0, 1);
        @(negedge clk);
        chk("stream_tail_count", {30'b0, count}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("drained_count", {30'b0, count}, 32'd0);

        // Backpressure: two fill the FIFO, the third is held off.
        out_ready = 1'b0;
        send(2'b01, 32'h0000_8000, 32'hFFFF_8000, 1'b0, 0);
        send(2'b10, 32'h0000_0001, 32'hFFFF_0001, 1'b0, 1);
        in_valid = 1'b1; opcode = 2'b01; move_in = 32'h5555_7FFF;
        @(negedge clk);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        chk("full_count", {30'b0, count}, 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_pop_count", {30'b0, count}, 32'd1);
        chk("after_pop_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        q.push_back('{d: 32'h0000_7FFF, ill: 1'b0});
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("third_count", {30'b0, count}, 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // Flush at full occupancy.
        out_ready = 1'b0;
        send(2'b01, 32'h1111_0005, 32'h0000_0005, 1'b0, 0);
        send(2'b00, 32'h2222_0006, 32'h0000_0000, 1'b1, 1);
        in_valid = 1'b1; opcode = 2'b10; move_in = 32'h0000_9999; flush = 1'b1;
        @(negedge clk);
        chk("flush_full_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        chk("flush_full_count", {30'b0, count}, 32'd0);
        chk("flush_full_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Flush while a push handshake is in progress.
        send(2'b01, 32'h0000_0042, 32'h0000_0042, 1'b0, 0);
        in_valid = 1'b1; opcode = 2'b10; move_in = 32'h0000_2222; flush = 1'b1;
        @(negedge clk);
        chk("flush_push_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        chk("flush_push_count", {30'b0, count}, 32'd0);
        chk("flush_push_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(2'b01, 32'h0000_7777, 32'h0000_7777, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-stream overrides flush and push.
        out_ready = 1'b0;
        send(2'b10, 32'h0000_ABCD, 32'hFFFF_ABCD, 1'b0, 0);
        send(2'b01, 32'h0000_8888, 32'hFFFF_8888, 1'b0, 1);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; opcode = 2'b01; move_in = 32'h0000_1234;
        @(negedge clk);
        chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_count", {30'b0, count}, 32'd0);
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_move_out", move_out, 32'd0);
        chk("rst_mid_illegal", {31'b0, out_illegal}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_rel_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_rel_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // XLEN == FLEN build: both legal opcodes pass through.
        b_in_valid = 1'b1; b_opcode = 2'b01; b_move_in = 16'h8001; b_out_ready = 1'b1;
        @(negedge clk);
        chk("w16_in_ready", {31'b0, b_in_ready}, 32'd1);
        @(posedge clk); #1;
        b_opcode = 2'b10;
        @(negedge clk);
        chk("w16_xf_valid", {31'b0, b_out_valid}, 32'd1);
        chk("w16_xf_move_out", {16'b0, b_move_out}, 32'h0000_8001);
        chk("w16_xf_illegal", {31'b0, b_out_illegal}, 32'd0);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("w16_fx_valid", {31'b0, b_out_valid}, 32'd1);
        chk("w16_fx_move_out", {16'b0, b_move_out}, 32'h0000_8001);
        chk("w16_fx_count", {30'b0, b_count}, 32'd1);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", q.size(), 32'd0);
        chk("max_count_le_depth", {31'b0, (max_cnt <= 2)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
